// File: rtl/sram2axi_bridge_mp_pkg.sv
// Shared AXI3 constants, write-channel state encoding and size helper for the
// multi-port SRAM-like to AXI bridge.
package sram2axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } wstate_e;

  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram2axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves to grant+1 whenever a grant is issued.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: indices at/above the pointer first, then the wrapped ones.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    if (en_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i >= 32'(ptr_q))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i < 32'(ptr_q))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram2axi_bridge_mp.sv
// NPORT SRAM-like request ports onto one AXI3 master: tagged outstanding reads,
// a single in-flight write, and a read-after-write word-address hazard check.
module sram2axi_bridge_mp
  import sram2axi_pkg::*;
#(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MAX_RD = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORT-1:0]              req_i,
  input  logic [NPORT-1:0]              wr_i,
  input  logic [NPORT-1:0][1:0]         size_i,
  input  logic [NPORT-1:0][3:0]         wstrb_i,
  input  logic [NPORT-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NPORT-1:0][DATA_W-1:0]  wdata_i,
  output logic [NPORT-1:0]              addr_ok_o,
  output logic [NPORT-1:0]              data_ok_o,
  output logic [NPORT-1:0][DATA_W-1:0]  rdata_o,
  output logic [ID_W-1:0]               arid_o,
  output logic [ADDR_W-1:0]             araddr_o,
  output logic [7:0]                    arlen_o,
  output logic [2:0]                    arsize_o,
  output logic [1:0]                    arburst_o,
  output logic [1:0]                    arlock_o,
  output logic [3:0]                    arcache_o,
  output logic [2:0]                    arprot_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,
  input  logic [ID_W-1:0]               rid_i,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [1:0]                    rresp_i,
  input  logic                          rlast_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  output logic [ID_W-1:0]               awid_o,
  output logic [ADDR_W-1:0]             awaddr_o,
  output logic [7:0]                    awlen_o,
  output logic [2:0]                    awsize_o,
  output logic [1:0]                    awburst_o,
  output logic [1:0]                    awlock_o,
  output logic [3:0]                    awcache_o,
  output logic [2:0]                    awprot_o,
  output logic                          awvalid_o,
  input  logic                          awready_i,
  output logic [ID_W-1:0]               wid_o,
  output logic [DATA_W-1:0]             wdata_o,
  output logic [3:0]                    wstrb_o,
  output logic                          wlast_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,
  input  logic [ID_W-1:0]               bid_i,
  input  logic [1:0]                    bresp_i,
  input  logic                          bvalid_i,
  output logic                          bready_o
);

  localparam int unsigned CW = $clog2(MAX_RD + 1);

  logic [NPORT-1:0][CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [NPORT-1:0]         rd_elig, wr_elig, rd_gnt, wr_gnt, r_hit, b_hit;
  logic                     ar_free, w_busy;

  wstate_e                  wst_q, wst_d;
  logic                     arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]        araddr_q, araddr_d;
  logic [2:0]               arsize_q, arsize_d;
  logic [ID_W-1:0]          arid_q, arid_d;
  logic                     awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [ADDR_W-1:0]        awaddr_q, awaddr_d;
  logic [2:0]               awsize_q, awsize_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [ID_W-1:0]          wid_q, wid_d;

  logic                     unused_ok;
  assign unused_ok = ^{rresp_i, rlast_i, bresp_i};

  assign ar_free = !arvalid_q || arready_i;
  assign w_busy  = (wst_q != W_IDLE);

  // Reads are held off for a port with its own write in flight and for any
  // read hitting the in-flight write's word, so per-port ordering holds.
  always_comb begin
    rd_elig = '0;
    wr_elig = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      rd_elig[p] = req_i[p] && !wr_i[p] && (rd_cnt_q[p] < CW'(MAX_RD)) &&
                   !(w_busy && ((wid_q == ID_W'(p)) ||
                                (addr_i[p][ADDR_W-1:2] == awaddr_q[ADDR_W-1:2])));
      wr_elig[p] = req_i[p] && wr_i[p] && (rd_cnt_q[p] == '0);
    end
  end

  rr_arbiter #(.N(NPORT)) u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (rd_elig),
    .en_i  (ar_free),
    .gnt_o (rd_gnt)
  );

  rr_arbiter #(.N(NPORT)) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (wr_elig),
    .en_i  (!w_busy),
    .gnt_o (wr_gnt)
  );

  always_comb begin
    r_hit    = '0;
    b_hit    = '0;
    rd_cnt_d = rd_cnt_q;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      r_hit[p]    = rvalid_i && (rid_i == ID_W'(p)) && (rd_cnt_q[p] != '0);
      b_hit[p]    = (wst_q == W_RESP) && bvalid_i && (bid_i == ID_W'(p));
      rd_cnt_d[p] = rd_cnt_q[p] + CW'(rd_gnt[p]) - CW'(r_hit[p]);
      rdata_o[p]  = rdata_i;
    end
  end

  assign addr_ok_o = rd_gnt | wr_gnt;
  assign data_ok_o = r_hit | b_hit;

  always_comb begin
    arvalid_d = arvalid_q && !arready_i;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arid_d    = arid_q;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (rd_gnt[p]) begin
        arvalid_d = 1'b1;
        araddr_d  = addr_i[p];
        arsize_d  = size_to_axsize(size_i[p]);
        arid_d    = ID_W'(p);
      end
    end
  end

  always_comb begin
    wst_d     = wst_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    wid_d     = wid_q;
    bready_o  = 1'b0;
    case (wst_q)
      W_IDLE: begin
        for (int unsigned p = 0; p < NPORT; p++) begin
          if (wr_gnt[p]) begin
            awaddr_d  = addr_i[p];
            awsize_d  = size_to_axsize(size_i[p]);
            wstrb_d   = wstrb_i[p];
            wdata_d   = wdata_i[p];
            wid_d     = ID_W'(p);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wst_d     = W_SEND;
          end
        end
      end
      W_SEND: begin
        awvalid_d = awvalid_q && !awready_i;
        wvalid_d  = wvalid_q && !wready_i;
        if (!awvalid_d && !wvalid_d) wst_d = W_RESP;
      end
      W_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q  <= '0;
      wst_q     <= W_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arid_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      wid_q     <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wst_q     <= wst_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arid_q    <= arid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      wid_q     <= wid_d;
    end
  end

  assign arid_o    = arid_q;
  assign araddr_o  = araddr_q;
  assign arlen_o   = '0;
  assign arsize_o  = arsize_q;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = AXI_LOCK_NORMAL;
  assign arcache_o = AXI_CACHE_NONE;
  assign arprot_o  = AXI_PROT_NONE;
  assign arvalid_o = arvalid_q;
  assign rready_o  = 1'b1;

  assign awid_o    = wid_q;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = '0;
  assign awsize_o  = awsize_q;
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = AXI_LOCK_NORMAL;
  assign awcache_o = AXI_CACHE_NONE;
  assign awprot_o  = AXI_PROT_NONE;
  assign awvalid_o = awvalid_q;
  assign wid_o     = wid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wvalid_q;

endmodule

// File: tb/tb_sram2axi_bridge_mp.sv
// Directed bench for sram2axi_bridge_mp with a per-port completion scoreboard.
module tb_sram2axi_bridge_mp;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req, wr;
  logic [1:0][1:0]   size;
  logic [1:0][3:0]   wstrb;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0]        addr_ok, data_ok;
  logic [1:0][31:0]  s_rdata;
  logic [3:0]        arid, rid, awid, wid, bid;
  logic [31:0]       araddr, awaddr, ax_rdata, ax_wdata;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, arprot, awprot;
  logic [1:0]        arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]        arcache, awcache, ax_wstrb;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram2axi_bridge_mp #(.NPORT(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_RD(2)) dut (
    .clk(clk), .reset(reset), .req_i(req), .wr_i(wr), .size_i(size), .wstrb_i(wstrb),
    .addr_i(addr), .wdata_i(wdata), .addr_ok_o(addr_ok), .data_ok_o(data_ok), .rdata_o(s_rdata),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot), .arvalid_o(arvalid),
    .arready_i(arready), .rid_i(rid), .rdata_i(ax_rdata), .rresp_i(rresp), .rlast_i(rlast),
    .rvalid_i(rvalid), .rready_o(rready), .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen),
    .awsize_o(awsize), .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache),
    .awprot_o(awprot), .awvalid_o(awvalid), .awready_i(awready), .wid_o(wid),
    .wdata_o(ax_wdata), .wstrb_o(ax_wstrb), .wlast_o(wlast), .wvalid_o(wvalid),
    .wready_i(wready), .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic rd, input logic [31:0] d);
    exp_t e;
    e.is_rd = rd;
    e.data  = d;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    req = '0; wr = '0; size = {2'd2, 2'd2}; wstrb = '0; addr = '0; wdata = '0;
    arready = 1'b0; rid = '0; ax_rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
  endtask

  task automatic do_reset();
    step(); reset = 1'b1; idle();
    step();
    step(); reset = 1'b0;
  endtask

  // Scoreboard: every data_ok must match the oldest expectation for that port.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (data_ok[p] === 1'b1) begin
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          chk("dok_unexpected", data_ok[p], 1'b0);
        end else begin
          if (p == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk("dok_kind", mon_e.is_rd, rvalid && (rid == 4'(p)));
          if (mon_e.is_rd) chk("dok_rdata", s_rdata[p], mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  logic [1:0]  alt_exp [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
  logic [31:0] alt_dat [4] = '{32'hA0A0_0001, 32'hB1B1_0001, 32'hA0A0_0002, 32'hB1B1_0002};
  logic [3:0]  ooo_rid [6] = '{4'd1, 4'd5, 4'd0, 4'd1, 4'd0, 4'd0};
  logic [31:0] ooo_dat [6] = '{32'hB1B1_0001, 32'h5555_5555, 32'hA0A0_0001,
                               32'hB1B1_0002, 32'hA0A0_0002, 32'h0BAD_0BAD};
  logic [1:0]  ooo_dok [6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};

  initial begin
    int ng;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    look();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b1);
    chk("rst_data_ok", data_ok, 2'b00);
    step(); reset = 1'b0;

    // Single read on port 0, then a write proving the read counter drained
    step(); req = 2'b01; addr[0] = 32'h1000; arready = 1'b1;
    look(); chk("rd1_addr_ok", addr_ok, 2'b01); push(0, 1'b1, 32'hDEADBEEF);
    chk("rd1_arvalid_t0", arvalid, 1'b0);
    step(); req = '0;
    look(); chk("rd1_arvalid", arvalid, 1'b1); chk("rd1_araddr", araddr, 32'h1000);
    chk("rd1_arid", arid, 4'd0); chk("rd1_arsize", arsize, 3'd2);
    chk("rd1_arlen", arlen, 8'd0); chk("rd1_arburst", arburst, 2'b01);
    step();
    look(); chk("rd1_arvalid_clr", arvalid, 1'b0);
    step(); rvalid = 1'b1; rid = 4'd0; ax_rdata = 32'hDEADBEEF;
    look(); chk("rd1_data_ok", data_ok, 2'b01);
    step(); rvalid = 1'b0;
    req = 2'b01; wr = 2'b01; addr[0] = 32'h4000; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF;
    look(); chk("wr0_addr_ok", addr_ok, 2'b01); push(0, 1'b0, '0);
    step(); req = '0; wr = '0; awready = 1'b1; wready = 1'b1;
    look(); chk("wr0_awvalid", awvalid, 1'b1); chk("wr0_wvalid", wvalid, 1'b1);
    chk("wr0_awaddr", awaddr, 32'h4000); chk("wr0_wdata", ax_wdata, 32'hCAFEF00D);
    chk("wr0_wstrb", ax_wstrb, 4'hF); chk("wr0_wlast", wlast, 1'b1); chk("wr0_bready", bready, 1'b0);
    step(); awready = 1'b0; wready = 1'b0;
    look(); chk("wr0_valids_clr", {awvalid, wvalid}, 2'b00); chk("wr0_bready_on", bready, 1'b1);
    step(); bvalid = 1'b1; bid = 4'd0;
    look(); chk("wr0_data_ok", data_ok, 2'b01);
    step(); bvalid = 1'b0;
    look(); chk("wr0_bready_off", bready, 1'b0);

    // Round-robin alternation until both ports hit MAX_RD
    do_reset();
    req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200; arready = 1'b1;
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      look();
      chk("alt_addr_ok", addr_ok, alt_exp[k]);
      if (addr_ok == 2'b01 || addr_ok == 2'b10) begin
        push((addr_ok == 2'b10) ? 1 : 0, 1'b1, alt_dat[ng]);
        ng++;
      end
      if (k > 0 && alt_exp[k-1] != 2'b00) chk("alt_arid", arid, (alt_exp[k-1] == 2'b10) ? 4'd1 : 4'd0);
      if (k > 0 && alt_exp[k-1] == 2'b00) chk("alt_arvalid_idle", arvalid, 1'b0);
    end
    step(); req = '0;

    // Out-of-order R beats, an out-of-range ID and a beat with no read pending
    for (int k = 0; k < 6; k++) begin
      rvalid = 1'b1; rid = ooo_rid[k]; ax_rdata = ooo_dat[k];
      look(); chk("ooo_data_ok", data_ok, ooo_dok[k]);
      step();
    end
    rvalid = 1'b0;

    // Write on port 1 with split AW/W handshakes
    req = 2'b10; wr = 2'b10; addr[1] = 32'h2000; wstrb[1] = 4'b0011; wdata[1] = 32'h11223344;
    look(); chk("wr1_addr_ok", addr_ok, 2'b10); push(1, 1'b0, '0);
    step(); req = '0; wr = '0; awready = 1'b1;
    look(); chk("wr1_valids", {awvalid, wvalid}, 2'b11); chk("wr1_awaddr", awaddr, 32'h2000);
    chk("wr1_awid", awid, 4'd1); chk("wr1_wid", wid, 4'd1); chk("wr1_wstrb", ax_wstrb, 4'b0011);
    chk("wr1_awsize", awsize, 3'd2);
    step(); awready = 1'b0;
    look(); chk("wr1_aw_done", {awvalid, wvalid}, 2'b01); chk("wr1_bready_c2", bready, 1'b0);
    step(); wready = 1'b1;
    look(); chk("wr1_wvalid_c3", wvalid, 1'b1); chk("wr1_bready_c3", bready, 1'b0);
    step(); wready = 1'b0;
    req = 2'b01; wr = 2'b01; addr[0] = 32'h6000; wdata[0] = 32'h0000600D; wstrb[0] = 4'hF;
    look(); chk("wr1_wvalid_c4", wvalid, 1'b0); chk("wr1_bready_c4", bready, 1'b1);
    chk("wr1_busy_c4", addr_ok, 2'b00);
    step(); bvalid = 1'b1; bid = 4'd1;
    look(); chk("wr1_data_ok", data_ok, 2'b10); chk("wr1_busy_c5", addr_ok, 2'b00);
    step(); bvalid = 1'b0;
    look(); chk("wr_next_addr_ok", addr_ok, 2'b01); chk("wr1_bready_off", bready, 1'b0);
    push(0, 1'b0, '0);
    step(); req = '0; wr = '0; awready = 1'b1; wready = 1'b1;
    look(); chk("wr2_awid", awid, 4'd0);
    step(); awready = 1'b0; wready = 1'b0;
    look(); chk("wr2_bready", bready, 1'b1);
    step(); bvalid = 1'b1; bid = 4'd0;
    look(); chk("wr2_data_ok", data_ok, 2'b01);
    step(); bvalid = 1'b0;

    // Read-after-write hazard against the in-flight write's word
    req = 2'b10; wr = 2'b10; addr[1] = 32'h2000;
    look(); chk("hz_wr_addr_ok", addr_ok, 2'b10); push(1, 1'b0, '0);
    step(); req = 2'b01; wr = '0; addr[0] = 32'h2002; arready = 1'b1;
    look(); chk("hz_blocked_a", addr_ok, 2'b00);
    step();
    look(); chk("hz_blocked_b", addr_ok, 2'b00);
    step(); addr[0] = 32'h3000;
    look(); chk("hz_other_ok", addr_ok, 2'b01); push(0, 1'b1, 32'h33333333);
    step(); addr[0] = 32'h2002;
    look(); chk("hz_blocked_c", addr_ok, 2'b00); chk("hz_araddr_3000", araddr, 32'h3000);
    step(); awready = 1'b1; wready = 1'b1;
    look(); chk("hz_blocked_send", addr_ok, 2'b00);
    step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
    look(); chk("hz_b_data_ok", data_ok, 2'b10); chk("hz_blocked_resp", addr_ok, 2'b00);
    step(); bvalid = 1'b0;
    look(); chk("hz_released", addr_ok, 2'b01); push(0, 1'b1, 32'h22222222);
    step(); req = '0;
    look(); chk("hz_araddr_2002", araddr, 32'h2002);
    step(); rvalid = 1'b1; rid = 4'd0; ax_rdata = 32'h33333333;
    look(); chk("hz_r1_data_ok", data_ok, 2'b01);
    step(); ax_rdata = 32'h22222222;
    look(); chk("hz_r2_data_ok", data_ok, 2'b01);
    step(); rvalid = 1'b0; arready = 1'b0;

    // Simultaneous read+write grants, then reset mid-transaction
    req = 2'b11; wr = 2'b10; addr[0] = 32'h7000; addr[1] = 32'h8000;
    look(); chk("both_addr_ok", addr_ok, 2'b11);
    step(); req = '0; wr = '0;
    look(); chk("pre_rst_valids", {arvalid, awvalid, wvalid}, 3'b111);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    look(); chk("post_rst_valids", {arvalid, awvalid, wvalid, bready}, 4'b0000);
    step(); rvalid = 1'b1; rid = 4'd0; ax_rdata = 32'h0BAD_0BAD; bvalid = 1'b1; bid = 4'd1;
    look(); chk("late_beats_dropped", data_ok, 2'b00);
    step(); idle(); req = 2'b01; wr = 2'b01; addr[0] = 32'h9000; wstrb[0] = 4'hF;
    look(); chk("post_rst_cnt0", addr_ok, 2'b01); push(0, 1'b0, '0);
    step(); req = '0; wr = '0; awready = 1'b1; wready = 1'b1;
    step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd0;
    look(); chk("post_rst_wr_done", data_ok, 2'b01);
    step(); bvalid = 1'b0;
    look();

    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
